uart_crc_link_ctrl: RTL

Transaction controller sitting in front of the UART/CRC loopback datapath. It arbitrates NUM_REQ byte-send requesters round-robin and launches the granted byte into the UART transmitter. It then waits for the receiver/CRC checker verdict, retries on CRC error, data mismatch or timeout, and reports per-requester done/fail pulses plus a saturating error counter.

---
 rtl/uart_crc_link_ctrl_pkg.sv | 16 +
 rtl/uart_crc_link_ctrl_rr_arbiter.sv | 31 +++
 rtl/uart_crc_link_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_crc_link_ctrl_pkg.sv
// Shared types for the UART/CRC link controller: FSM encoding and counter widths.
package uart_crc_pkg;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_RX,
    S_CHECK,
    S_EVAL,
    S_WAIT_IDLE,
    S_RELEASE
  } state_t;

endpackage

// File: rtl/uart_crc_link_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  int w_pos;

  always_comb begin
    o_valid = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    w_pos   = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_pos = int'(i_ptr) + off;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      if (!o_valid && i_req[w_pos]) begin
        o_valid        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/uart_crc_link_ctrl.sv
// Round-robin byte-send controller for the UART/CRC loopback path, with
// retry on CRC error / data mismatch / timeout and a saturating error counter.
module uart_crc_link_ctrl
  import uart_crc_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     fail,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  input  logic                   rx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   crc_error,
  output logic                   busy,
  output logic [ERR_CNT_W-1:0]   err_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int AT_W  = $clog2(MAX_RETRY + 1) + 1;
  // Terminal count leaves room for EVAL and WAIT_IDLE so that, with the
  // transmitter idle, consecutive timed-out launches are TIMEOUT_CYCLES apart.
  localparam logic [TO_W-1:0] TO_TERM = TO_W'(TIMEOUT_CYCLES - 4);

  state_t                 r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_idx, r_ptr;
  logic [7:0]             r_tx_data, r_rx_data;
  logic                   r_good;
  logic [AT_W-1:0]        r_attempt;
  logic [TO_W-1:0]        r_to_cnt;
  logic [ERR_CNT_W-1:0]   r_err_cnt;
  logic [NUM_REQ-1:0]     r_done, r_fail;

  logic                   w_gnt_vld;
  logic [NUM_REQ-1:0]     w_gnt;
  logic [IDX_W-1:0]       w_gnt_idx;
  logic [7:0]             w_gnt_byte;
  logic                   w_timeout;
  logic                   w_retry_ok;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_valid (w_gnt_vld),
    .o_grant (w_gnt),
    .o_idx   (w_gnt_idx)
  );

  always_comb begin
    w_gnt_byte = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_gnt[i]) w_gnt_byte = w_gnt_byte | req_data[8*i +: 8];
  end

  assign w_timeout  = (r_to_cnt == TO_TERM);
  assign w_retry_ok = (r_attempt < AT_W'(MAX_RETRY));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_gnt_vld && !tx_busy) w_state_nxt = S_LAUNCH;
      S_LAUNCH:    w_state_nxt = S_WAIT_RX;
      S_WAIT_RX:   if (rx_ready)       w_state_nxt = S_CHECK;
                   else if (w_timeout) w_state_nxt = S_EVAL;
      S_CHECK:     w_state_nxt = S_EVAL;
      S_EVAL:      if (!r_good && w_retry_ok) w_state_nxt = S_WAIT_IDLE;
                   else                       w_state_nxt = S_RELEASE;
      S_WAIT_IDLE: if (!tx_busy) w_state_nxt = S_LAUNCH;
      S_RELEASE:   w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx     <= '0;
      r_ptr     <= '0;
      r_tx_data <= '0;
      r_rx_data <= '0;
      r_good    <= 1'b0;
      r_attempt <= '0;
      r_to_cnt  <= '0;
      r_err_cnt <= '0;
      r_done    <= '0;
      r_fail    <= '0;
    end else begin
      r_done <= '0;
      r_fail <= '0;
      case (r_state)
        S_IDLE: if (w_gnt_vld && !tx_busy) begin
          r_idx     <= w_gnt_idx;
          r_tx_data <= w_gnt_byte;
          r_attempt <= '0;
        end
        S_LAUNCH: r_to_cnt <= '0;
        S_WAIT_RX: begin
          r_to_cnt <= r_to_cnt + 1'b1;
          if (rx_ready)       r_rx_data <= rx_data;
          else if (w_timeout) r_good    <= 1'b0;
        end
        S_CHECK: r_good <= !crc_error && (r_rx_data == r_tx_data);
        S_EVAL: begin
          if (r_good) begin
            r_done[r_idx] <= 1'b1;
          end else begin
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            if (w_retry_ok) r_attempt     <= r_attempt + 1'b1;
            else            r_fail[r_idx] <= 1'b1;
          end
        end
        S_RELEASE: r_ptr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign done      = r_done;
  assign fail      = r_fail;
  assign tx_data   = r_tx_data;
  assign tx_start  = (r_state == S_LAUNCH);
  assign busy      = (r_state != S_IDLE);
  assign err_count = r_err_cnt;

endmodule
